crc_engine: RTL and testbench

Parametrised serial CRC engine for the USB receive/transmit datapath. It works on the unstuffed bit stream and has two modes. Check mode compares the final register against a configurable residue. Generate mode shifts the (optionally complemented) CRC out MSB-first under a valid/ready handshake. One instance with WIDTH=5 serves token packets, and one with WIDTH=16 serves data packets.

---
 rtl/crc_engine.sv | 142 ++++++++++++++
 tb/tb_crc_engine.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// ============================================================================
// Module   : crc_engine
// Purpose  : Serial MSB-first CRC engine with residue check and handshaked
//            CRC emission for the USB bit-level datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_engine #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'h8005,
    parameter logic [WIDTH-1:0] INIT       = '1,
    parameter logic [WIDTH-1:0] RESIDUE    = 16'h800D,
    parameter bit               INVERT_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             check_req,
    input  logic             emit_req,
    input  logic             emit_ready,
    output logic             emit_valid,
    output logic             emit_bit,
    output logic             emit_last,
    output logic             crc_done,
    output logic             crc_passed,
    output logic             crc_err,
    output logic [WIDTH-1:0] crc_value
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        EMIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_crc, w_crc_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic             r_passed, w_passed_nxt;
    logic             r_err, w_err_nxt;

    logic             w_fb;
    logic [WIDTH-1:0] w_crc_step;
    logic [WIDTH-1:0] w_crc_acc;
    logic             w_accept;
    logic             w_proto_err;

    assign w_fb       = bit_in ^ r_crc[WIDTH-1];
    assign w_crc_step = {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    // Register value including a same-cycle bit; used by both verdict and emission load.
    assign w_crc_acc  = (r_state == ACCUM && bit_valid) ? w_crc_step : r_crc;
    assign w_accept   = (r_state == EMIT) && emit_ready;

    assign w_proto_err = (bit_valid && (r_state != ACCUM))
                       || ((check_req || emit_req) && (r_state != ACCUM))
                       || (check_req && emit_req);

    always_comb begin
        w_state_nxt  = r_state;
        w_crc_nxt    = r_crc;
        w_shreg_nxt  = r_shreg;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = r_done;
        w_passed_nxt = r_passed;
        w_err_nxt    = r_err | w_proto_err;

        if (init) begin
            w_state_nxt  = ACCUM;
            w_crc_nxt    = INIT;
            w_done_nxt   = 1'b0;
            w_passed_nxt = 1'b0;
            w_err_nxt    = 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    w_crc_nxt = w_crc_acc;
                    if (check_req) begin
                        w_state_nxt  = RESULT;
                        w_passed_nxt = (w_crc_acc == RESIDUE);
                        w_done_nxt   = 1'b1;
                    end else if (emit_req) begin
                        w_state_nxt = EMIT;
                        w_shreg_nxt = INVERT_OUT ? ~w_crc_acc : w_crc_acc;
                        w_cnt_nxt   = CW'(WIDTH - 1);
                    end
                end
                EMIT: begin
                    if (w_accept) begin
                        w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                        w_cnt_nxt   = r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            w_state_nxt  = RESULT;
                            w_done_nxt   = 1'b1;
                            w_passed_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_crc    <= INIT;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_passed <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_crc    <= w_crc_nxt;
            r_shreg  <= w_shreg_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_passed <= w_passed_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign emit_valid = (r_state == EMIT);
    assign emit_bit   = (r_state == EMIT) && r_shreg[WIDTH-1];
    assign emit_last  = (r_state == EMIT) && (r_cnt == '0);
    assign crc_done   = r_done;
    assign crc_passed = r_passed;
    assign crc_err    = r_err;
    assign crc_value  = r_crc;

endmodule

`default_nettype wire

// File: tb/tb_crc_engine.sv
// ============================================================================
// Module   : tb_crc_engine
// Purpose  : Scoreboard bench for crc_engine in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init, bit_valid, bit_in, check_req, emit_req, emit_ready;

    always #5 clk = ~clk;

    logic        a_ev, a_eb, a_el, a_done, a_pass, a_err;
    logic [15:0] a_crc;
    logic        z_ev, z_eb, z_el, z_done, z_pass, z_err;
    logic [15:0] z_crc;
    logic        t_ev, t_eb, t_el, t_done, t_pass, t_err;
    logic [4:0]  t_crc;

    crc_engine u_a (
        .clk(clk), .rst(rst), .init(init), .bit_valid(bit_valid), .bit_in(bit_in),
        .check_req(check_req), .emit_req(emit_req), .emit_ready(emit_ready),
        .emit_valid(a_ev), .emit_bit(a_eb), .emit_last(a_el), .crc_done(a_done),
        .crc_passed(a_pass), .crc_err(a_err), .crc_value(a_crc)
    );

    crc_engine #(.WIDTH(16), .POLY(16'h8005), .INIT(16'h0000), .RESIDUE(16'h0000),
                 .INVERT_OUT(1'b0)) u_z (
        .clk(clk), .rst(rst), .init(init), .bit_valid(bit_valid), .bit_in(bit_in),
        .check_req(check_req), .emit_req(emit_req), .emit_ready(emit_ready),
        .emit_valid(z_ev), .emit_bit(z_eb), .emit_last(z_el), .crc_done(z_done),
        .crc_passed(z_pass), .crc_err(z_err), .crc_value(z_crc)
    );

    crc_engine #(.WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C),
                 .INVERT_OUT(1'b1)) u_t (
        .clk(clk), .rst(rst), .init(init), .bit_valid(bit_valid), .bit_in(bit_in),
        .check_req(check_req), .emit_req(emit_req), .emit_ready(emit_ready),
        .emit_valid(t_ev), .emit_bit(t_eb), .emit_last(t_el), .crc_done(t_done),
        .crc_passed(t_pass), .crc_err(t_err), .crc_value(t_crc)
    );

    int          sel = 0;
    logic        m_valid, m_bit, m_last, m_done, m_pass, m_err;
    logic [31:0] m_crc_v;

    always_comb begin
        case (sel)
            0: begin
                m_valid = a_ev; m_bit = a_eb; m_last = a_el;
                m_done = a_done; m_pass = a_pass; m_err = a_err; m_crc_v = {16'b0, a_crc};
            end
            1: begin
                m_valid = z_ev; m_bit = z_eb; m_last = z_el;
                m_done = z_done; m_pass = z_pass; m_err = z_err; m_crc_v = {16'b0, z_crc};
            end
            default: begin
                m_valid = t_ev; m_bit = t_eb; m_last = t_el;
                m_done = t_done; m_pass = t_pass; m_err = t_err; m_crc_v = {27'b0, t_crc};
            end
        endcase
    end

    int          checks = 0;
    int          errors = 0;
    int          W;
    logic [31:0] P, I, R, MASK;
    bit          INV;
    logic [31:0] m_crc;
    logic [31:0] last_e;
    logic        bq[$];
    logic        vq[$];

    task automatic set_cfg(input int s);
        sel = s;
        case (s)
            0:       begin W = 16; P = 32'h8005; I = 32'hFFFF; R = 32'h800D; INV = 1'b1; end
            1:       begin W = 16; P = 32'h8005; I = 32'h0000; R = 32'h0000; INV = 1'b0; end
            default: begin W = 5;  P = 32'h05;   I = 32'h1F;   R = 32'h0C;   INV = 1'b1; end
        endcase
        MASK = (32'd1 << W) - 32'd1;
    endtask

    function automatic logic [31:0] mstep(input logic [31:0] c, input logic b);
        logic fb;
        fb = b ^ c[W-1];
        return ((c << 1) ^ (fb ? P : 32'd0)) & MASK;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        init = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        check_req = 1'b0; emit_req = 1'b0; emit_ready = 1'b0;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        m_crc = I;
    endtask

    task automatic feed(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        m_crc     = mstep(m_crc, b);
    endtask

    task automatic feed_vec(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) feed(v[i]);
    endtask

    task automatic do_check(input logic wb, input logic b, input logic want, input string nm);
        logic exp;
        check_req = 1'b1;
        if (wb) begin
            bit_valid = 1'b1;
            bit_in    = b;
            m_crc     = mstep(m_crc, b);
        end
        vq.push_back(want);
        tick();
        check_req = 1'b0;
        bit_valid = 1'b0;
        exp = vq.pop_front();
        checks++;
        if (m_done !== 1'b1 || m_pass !== exp) begin
            errors++;
            $display("FAIL %s verdict: done=%b passed=%b, expected done=1 passed=%b", nm, m_done, m_pass, exp);
        end
        checks++;
        if (m_crc_v !== m_crc) begin
            errors++;
            $display("FAIL %s crc_value: got %0h, expected %0h", nm, m_crc_v, m_crc);
        end
    endtask

    task automatic do_emit(input bit rnd, input string nm);
        logic [31:0] e;
        logic        exp, pv, pr, pb;
        int          acc, cyc, first;
        e = (INV ? ~m_crc : m_crc) & MASK;
        last_e = e;
        for (int i = W - 1; i >= 0; i--) bq.push_back(e[i]);
        emit_req = 1'b1;
        tick();
        emit_req = 1'b0;
        acc = 0; cyc = 0; first = -1; pv = 1'b0; pr = 1'b0; pb = 1'b0;
        while (!m_done && cyc < 200) begin
            emit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid) begin
                if (first < 0) first = cyc;
                if (pv && !pr) begin
                    checks++;
                    if (m_bit !== pb) begin
                        errors++;
                        $display("FAIL %s stall_stable: got %b, expected %b", nm, m_bit, pb);
                    end
                end
                checks++;
                if (m_last !== (bq.size() == 1)) begin
                    errors++;
                    $display("FAIL %s emit_last: got %b, expected %b (bit %0d)", nm, m_last, bq.size() == 1, acc);
                end
                if (emit_ready) begin
                    exp = (bq.size() > 0) ? bq.pop_front() : 1'bx;
                    checks++;
                    if (m_bit !== exp) begin
                        errors++;
                        $display("FAIL %s emit_bit[%0d]: got %b, expected %b", nm, acc, m_bit, exp);
                    end
                    acc++;
                end
            end
            pv = m_valid; pr = emit_ready; pb = m_bit;
            tick();
            cyc++;
        end
        emit_ready = 1'b0;
        checks++;
        if (!m_done || acc != W || m_pass !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s completion: done=%b accepted=%0d passed=%b valid=%b, expected 1/%0d/0/0",
                     nm, m_done, acc, m_pass, m_valid, W);
        end
        if (!rnd) begin
            checks++;
            if (first != 0 || cyc - first != W) begin
                errors++;
                $display("FAIL %s latency: first=%0d done_after=%0d, expected 0/%0d", nm, first, cyc - first, W);
            end
        end
        bq.delete();
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        #12;
        checks++;
        if (a_crc !== 16'hFFFF || z_crc !== 16'h0000 || t_crc !== 5'h1F) begin
            errors++;
            $display("FAIL reset crc_value: got %h/%h/%h, expected ffff/0000/1f", a_crc, z_crc, t_crc);
        end
        checks++;
        if ({a_ev, a_eb, a_el, a_done, a_pass, a_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset outputs: got %b, expected 000000", {a_ev, a_eb, a_el, a_done, a_pass, a_err});
        end
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_single_bit();
        set_cfg(1);
        do_init();
        feed(1'b1);
        checks++;
        if (m_crc_v !== 32'h8005) begin
            errors++;
            $display("FAIL single_bit crc_value: got %0h, expected 8005", m_crc_v);
        end
        do_check(1'b0, 1'b0, 1'b0, "single_bit");
    endtask

    task automatic test_gen_zero();
        set_cfg(0);
        do_init();
        do_emit(1'b0, "gen_zero");
        do_init();
        for (int i = 0; i < 16; i++) feed(1'b0);
        do_check(1'b0, 1'b0, 1'b1, "zero_residue");
        checks++;
        if (m_crc_v !== 32'h800D) begin
            errors++;
            $display("FAIL zero_residue value: got %0h, expected 800d", m_crc_v);
        end
    endtask

    task automatic test_round_trip(input int s, input string nm);
        logic [63:0] data;
        logic [31:0] e;
        int          k;
        set_cfg(s);
        data = {$urandom, $urandom};
        do_init();
        feed_vec(data, 64);
        do_emit(1'b0, nm);
        e = last_e;
        do_init();
        feed_vec(data, 64);
        for (int i = W - 1; i >= 0; i--) feed(e[i]);
        do_check(1'b0, 1'b0, 1'b1, nm);
        k = $urandom_range(0, 63);
        do_init();
        feed_vec(data ^ (64'd1 << k), 64);
        for (int i = W - 1; i >= 0; i--) feed(e[i]);
        do_check(1'b0, 1'b0, 1'b0, {nm, "_flip"});
    endtask

    task automatic test_backpressure();
        set_cfg(0);
        do_init();
        feed_vec({$urandom, $urandom}, 20);
        do_emit(1'b1, "backpressure");
        do_init();
        feed_vec({$urandom, $urandom}, 8);
        emit_req = 1'b1;
        tick();
        emit_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            emit_ready = 1'($urandom_range(0, 1));
            tick();
        end
        emit_ready = 1'b0;
        init = 1'b1;
        tick();
        init = 1'b0;
        m_crc = I;
        checks++;
        if (m_valid !== 1'b0 || m_crc_v !== 32'hFFFF || m_done !== 1'b0) begin
            errors++;
            $display("FAIL emit_abort: valid=%b crc=%0h done=%b, expected 0/ffff/0", m_valid, m_crc_v, m_done);
        end
    endtask

    task automatic test_protocol();
        logic [31:0] keep;
        logic        b;
        set_cfg(0);
        do_init();
        feed_vec({$urandom, $urandom}, 10);
        b = 1'($urandom_range(0, 1));
        do_check(1'b1, b, (mstep(m_crc, b) == R), "check_with_bit");
        keep = m_crc;
        bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        bit_valid = 1'b0;
        checks++;
        if (m_err !== 1'b1 || m_crc_v !== keep) begin
            errors++;
            $display("FAIL bit_in_result: err=%b crc=%0h, expected 1/%0h", m_err, m_crc_v, keep);
        end
        do_init();
        feed_vec({$urandom, $urandom}, 3);
        check_req = 1'b1; emit_req = 1'b1;
        tick();
        check_req = 1'b0; emit_req = 1'b0;
        checks++;
        if (m_err !== 1'b1 || m_done !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL check_and_emit: err=%b done=%b valid=%b, expected 1/1/0", m_err, m_done, m_valid);
        end
        init = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        init = 1'b0; bit_valid = 1'b0;
        m_crc = I;
        checks++;
        if (m_crc_v !== 32'hFFFF || m_err !== 1'b0 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL init_with_bit: crc=%0h err=%b done=%b, expected ffff/0/0", m_crc_v, m_err, m_done);
        end
    endtask

    task automatic test_rst_mid_packet();
        set_cfg(0);
        do_init();
        feed_vec({$urandom, $urandom}, 5);
        bit_valid = 1'b1; bit_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_crc !== 16'hFFFF || {a_ev, a_eb, a_el, a_done, a_pass, a_err} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_packet: crc=%h outs=%b, expected ffff/000000",
                     a_crc, {a_ev, a_eb, a_el, a_done, a_pass, a_err});
        end
        clear_in();
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        set_cfg(0);
        m_crc = I;
        test_reset();
        test_single_bit();
        test_gen_zero();
        test_round_trip(0, "rt16");
        test_round_trip(2, "rt5");
        test_backpressure();
        test_protocol();
        test_rst_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
